// File: rtl/sobel_gcd_pkg.sv
// Opcodes, FSM state type and shared constants for the SPI command sequencer.
package sobel_gcd_pkg;

    localparam logic [7:0] OP_GCD    = 8'h01;
    localparam logic [7:0] OP_SOBEL  = 8'h02;
    localparam logic [7:0] OP_STATUS = 8'h03;

    localparam int         ERR_CNT_W    = 5;
    localparam logic [7:0] TIMEOUT_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_ARGS,
        ST_GCD_RUN,
        ST_SOBEL_RUN,
        ST_TX
    } cmd_state_e;

    function automatic logic is_valid_op(input logic [7:0] op);
        return (op == OP_GCD) || (op == OP_SOBEL) || (op == OP_STATUS);
    endfunction

endpackage

// File: rtl/sobel_gcd_tx_serializer.sv
// Holds a result word and offers it MSB byte first under tx_valid/tx_ready handshaking.
module sobel_gcd_tx_serializer #(
    parameter int NBYTES = 2,
    parameter int CNT_W  = $clog2(NBYTES + 1)
) (
    input  logic                  clk_i,
    input  logic                  nreset_i,
    input  logic                  load_i,
    input  logic                  abort_i,
    input  logic [8*NBYTES-1:0]   data_i,
    input  logic [CNT_W-1:0]      nbytes_i,
    input  logic                  tx_ready_i,
    output logic [7:0]            tx_byte_o,
    output logic                  tx_valid_o,
    output logic                  done_o
);

    logic [8*NBYTES-1:0] shreg;
    logic [CNT_W-1:0]    remaining;

    assign tx_byte_o = shreg[8*NBYTES-1 -: 8];
    assign done_o    = tx_valid_o && tx_ready_i && (remaining == CNT_W'(1));

    // A load coinciding with an abort is a fresh command and must win.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            shreg      <= '0;
            remaining  <= '0;
            tx_valid_o <= 1'b0;
        end else if (load_i) begin
            shreg      <= data_i;
            remaining  <= nbytes_i;
            tx_valid_o <= 1'b1;
        end else if (abort_i) begin
            shreg      <= '0;
            remaining  <= '0;
            tx_valid_o <= 1'b0;
        end else if (tx_valid_o && tx_ready_i) begin
            shreg     <= shreg << 8;
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1))
                tx_valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/sobel_gcd_cmd_ctrl.sv
// SPI command sequencer for the GCD and Sobel engines.
// Optional engine-wait timeout is enabled with macro SOBEL_GCD_CMD_TIMEOUT_EN.
//
// state        | meaning
// ST_IDLE      | waiting for an opcode byte
// ST_RX_ARGS   | collecting operand / pixel bytes
// ST_GCD_RUN   | gcd_enable_o high, waiting for gcd_done_i
// ST_SOBEL_RUN | prep_allowed_o high, waiting for pixel_completed_i
// ST_TX        | serializer returning result bytes
module sobel_gcd_cmd_ctrl #(
    parameter int GCD_WIDTH      = 16,
    parameter int PX_WIDTH       = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk_i,
    input  logic                  nreset_i,
    input  logic                  frame_start_i,
    input  logic [7:0]            rx_byte_i,
    input  logic                  rx_valid_i,
    output logic [7:0]            tx_byte_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic [GCD_WIDTH-1:0]  operand_a_o,
    output logic [GCD_WIDTH-1:0]  operand_b_o,
    output logic                  gcd_enable_o,
    input  logic [GCD_WIDTH-1:0]  gcd_i,
    input  logic                  gcd_done_i,
    output logic [9*PX_WIDTH-1:0] input_px_gray_o,
    output logic                  prep_allowed_o,
    input  logic [PX_WIDTH-1:0]   output_px_sobel_i,
    input  logic                  pixel_completed_i,
    output logic                  busy_o
);
    import sobel_gcd_pkg::*;

    localparam int NB         = GCD_WIDTH / 8;
    localparam int GCD_ARGS   = 2 * NB;
    localparam int SOBEL_ARGS = 9;
    localparam int ARG_W      = $clog2(((GCD_ARGS > SOBEL_ARGS) ? GCD_ARGS : SOBEL_ARGS) + 1);
    localparam int NB_W       = $clog2(NB + 1);

    cmd_state_e             state;
    logic [ARG_W-1:0]       arg_cnt;
    logic                   arg_is_gcd;
    logic [1:0]             last_op;
    logic [ERR_CNT_W-1:0]   err_cnt;
    logic [2*GCD_WIDTH-1:0] opnd_sr;

    logic                   decode_now, run_start, gcd_fin, sobel_fin, timeout_hit, err_inc;
    logic                   ser_load, ser_done;
    logic [GCD_WIDTH-1:0]   ser_data;
    logic [NB_W-1:0]        ser_nbytes;
    logic [7:0]             status_byte;

    // frame_start_i turns the current byte into an opcode regardless of state.
    assign decode_now  = rx_valid_i && (frame_start_i || state == ST_IDLE);
    assign run_start   = !frame_start_i && state == ST_RX_ARGS && rx_valid_i
                         && arg_cnt == ARG_W'(1);
    assign gcd_fin     = !frame_start_i && state == ST_GCD_RUN && gcd_done_i;
    assign sobel_fin   = !frame_start_i && state == ST_SOBEL_RUN && pixel_completed_i;
    assign status_byte = {1'b0, last_op, err_cnt};

    assign operand_a_o = opnd_sr[2*GCD_WIDTH-1:GCD_WIDTH];
    assign operand_b_o = opnd_sr[GCD_WIDTH-1:0];
    assign busy_o      = (state != ST_IDLE);

`ifdef SOBEL_GCD_CMD_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMR_W-1:0] wait_tmr;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i)
            wait_tmr <= '0;
        else if (run_start)
            wait_tmr <= TMR_W'(TIMEOUT_CYCLES - 1);
        else if ((state == ST_GCD_RUN || state == ST_SOBEL_RUN) && wait_tmr != '0)
            wait_tmr <= wait_tmr - 1'b1;
    end

    assign timeout_hit = !frame_start_i && wait_tmr == '0
                         && ((state == ST_GCD_RUN && !gcd_done_i)
                          || (state == ST_SOBEL_RUN && !pixel_completed_i));
`else
    assign timeout_hit = 1'b0;
`endif

    assign err_inc = (decode_now && !is_valid_op(rx_byte_i))
                   || (rx_valid_i && !frame_start_i
                       && (state == ST_GCD_RUN || state == ST_SOBEL_RUN || state == ST_TX))
                   || timeout_hit;

    // Single-byte results sit in the top byte since the serializer sends MSB first.
    always_comb begin
        ser_load   = 1'b0;
        ser_data   = '0;
        ser_nbytes = '0;
        if (decode_now && rx_byte_i == OP_STATUS) begin
            ser_load   = 1'b1;
            ser_data   = GCD_WIDTH'(status_byte) << (GCD_WIDTH - 8);
            ser_nbytes = NB_W'(1);
        end else if (gcd_fin) begin
            ser_load   = 1'b1;
            ser_data   = gcd_i;
            ser_nbytes = NB_W'(NB);
        end else if (sobel_fin) begin
            ser_load   = 1'b1;
            ser_data   = GCD_WIDTH'(output_px_sobel_i) << (GCD_WIDTH - 8);
            ser_nbytes = NB_W'(1);
        end else if (timeout_hit) begin
            ser_load   = 1'b1;
            ser_data   = {NB{TIMEOUT_BYTE}};
            ser_nbytes = (state == ST_GCD_RUN) ? NB_W'(NB) : NB_W'(1);
        end
    end

    sobel_gcd_tx_serializer #(
        .NBYTES (NB),
        .CNT_W  (NB_W)
    ) u_tx_ser (
        .clk_i      (clk_i),
        .nreset_i   (nreset_i),
        .load_i     (ser_load),
        .abort_i    (frame_start_i),
        .data_i     (ser_data),
        .nbytes_i   (ser_nbytes),
        .tx_ready_i (tx_ready_i),
        .tx_byte_o  (tx_byte_o),
        .tx_valid_o (tx_valid_o),
        .done_o     (ser_done)
    );

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state           <= ST_IDLE;
            arg_cnt         <= '0;
            arg_is_gcd      <= 1'b0;
            last_op         <= '0;
            err_cnt         <= '0;
            opnd_sr         <= '0;
            input_px_gray_o <= '0;
            gcd_enable_o    <= 1'b0;
            prep_allowed_o  <= 1'b0;
        end else begin
            if (err_inc && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;

            if (frame_start_i || state == ST_IDLE) begin
                state          <= ST_IDLE;
                arg_cnt        <= '0;
                gcd_enable_o   <= 1'b0;
                prep_allowed_o <= 1'b0;
                if (rx_valid_i) begin
                    case (rx_byte_i)
                        OP_GCD: begin
                            state      <= ST_RX_ARGS;
                            arg_cnt    <= ARG_W'(GCD_ARGS);
                            arg_is_gcd <= 1'b1;
                            last_op    <= 2'd1;
                        end
                        OP_SOBEL: begin
                            state      <= ST_RX_ARGS;
                            arg_cnt    <= ARG_W'(SOBEL_ARGS);
                            arg_is_gcd <= 1'b0;
                            last_op    <= 2'd2;
                        end
                        OP_STATUS: begin
                            state   <= ST_TX;
                            last_op <= 2'd3;
                        end
                        default: ;
                    endcase
                end
            end else begin
                case (state)
                    ST_RX_ARGS: begin
                        if (rx_valid_i) begin
                            arg_cnt <= arg_cnt - 1'b1;
                            if (arg_is_gcd)
                                opnd_sr <= {opnd_sr[2*GCD_WIDTH-9:0], rx_byte_i};
                            else
                                input_px_gray_o <= {rx_byte_i, input_px_gray_o[9*PX_WIDTH-1:8]};
                            if (run_start) begin
                                state          <= arg_is_gcd ? ST_GCD_RUN : ST_SOBEL_RUN;
                                gcd_enable_o   <= arg_is_gcd;
                                prep_allowed_o <= !arg_is_gcd;
                            end
                        end
                    end
                    ST_GCD_RUN: begin
                        if (gcd_done_i || timeout_hit) begin
                            gcd_enable_o <= 1'b0;
                            state        <= ST_TX;
                        end
                    end
                    ST_SOBEL_RUN: begin
                        if (pixel_completed_i || timeout_hit) begin
                            prep_allowed_o <= 1'b0;
                            state          <= ST_TX;
                        end
                    end
                    ST_TX: begin
                        if (ser_done)
                            state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sobel_gcd_cmd_ctrl.sv
// Directed bench for sobel_gcd_cmd_ctrl; a protocol-level model predicts every returned byte.
module tb_sobel_gcd_cmd_ctrl;

    logic        clk_i = 1'b0;
    logic        nreset_i = 1'b0;
    logic        frame_start_i = 1'b0;
    logic [7:0]  rx_byte_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  tx_byte_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b1;
    logic [15:0] operand_a_o, operand_b_o;
    logic        gcd_enable_o;
    logic [15:0] gcd_i = 16'h0;
    logic        gcd_done_i = 1'b0;
    logic [71:0] input_px_gray_o;
    logic        prep_allowed_o;
    logic [7:0]  output_px_sobel_i = 8'h00;
    logic        pixel_completed_i = 1'b0;
    logic        busy_o;

    int          total = 0;
    int          bad = 0;
    logic        allow_run = 1'b0;
    logic [7:0]  exp_q[$];
    int          m_err = 0;
    int          m_last = 0;
    logic [71:0] m_win;
    int          n_en;

    sobel_gcd_cmd_ctrl #(
        .GCD_WIDTH      (16),
        .PX_WIDTH       (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i             (clk_i),
        .nreset_i          (nreset_i),
        .frame_start_i     (frame_start_i),
        .rx_byte_i         (rx_byte_i),
        .rx_valid_i        (rx_valid_i),
        .tx_byte_o         (tx_byte_o),
        .tx_valid_o        (tx_valid_o),
        .tx_ready_i        (tx_ready_i),
        .operand_a_o       (operand_a_o),
        .operand_b_o       (operand_b_o),
        .gcd_enable_o      (gcd_enable_o),
        .gcd_i             (gcd_i),
        .gcd_done_i        (gcd_done_i),
        .input_px_gray_o   (input_px_gray_o),
        .prep_allowed_o    (prep_allowed_o),
        .output_px_sobel_i (output_px_sobel_i),
        .pixel_completed_i (pixel_completed_i),
        .busy_o            (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int gcd_ref(input int a, input int b);
        int x = a, y = b, t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic void err_bump();
        if (m_err < 31) m_err++;
    endfunction

    // Opcode rules: STATUS reports the last_op from before itself; unknown opcodes count errors.
    function automatic void model_op(input logic [7:0] b);
        logic [7:0] s;
        if (b == 8'h01 || b == 8'h02) begin
            m_last = int'(b);
        end else if (b == 8'h03) begin
            s = {1'b0, 2'(m_last), 5'(m_err)};
            exp_q.push_back(s);
            m_last = 3;
        end else begin
            err_bump();
        end
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic fs);
        rx_byte_i     = b;
        rx_valid_i    = 1'b1;
        frame_start_i = fs;
        tick();
        rx_valid_i    = 1'b0;
        frame_start_i = 1'b0;
    endtask

    task automatic gcd_frame(input logic [15:0] a, input logic [15:0] b);
        allow_run = 1'b1;
        send_byte(8'h01, 1'b1);
        model_op(8'h01);
        send_byte(a[15:8], 1'b0);
        send_byte(a[7:0], 1'b0);
        send_byte(b[15:8], 1'b0);
        check("gcd_enable_before_last", gcd_enable_o, 1'b0);
        send_byte(b[7:0], 1'b0);
        check("gcd_enable_latency", gcd_enable_o, 1'b1);
        check("operand_a", operand_a_o, a);
        check("operand_b", operand_b_o, b);
    endtask

    task automatic gcd_done_pulse(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] g;
        g = 16'(gcd_ref(int'(a), int'(b)));
        gcd_i      = g;
        gcd_done_i = 1'b1;
        exp_q.push_back(g[15:8]);
        exp_q.push_back(g[7:0]);
        tick();
        gcd_done_i = 1'b0;
        gcd_i      = 16'h0;
        allow_run  = 1'b0;
        check("gcd_done_to_tx_valid", tx_valid_o, 1'b1);
        check("gcd_enable_dropped", gcd_enable_o, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_valid"}, tx_valid_o, 1'b0);
        check({tag, "_tx_byte"}, tx_byte_o, 8'h00);
        check({tag, "_busy"}, busy_o, 1'b0);
        check({tag, "_gcd_enable"}, gcd_enable_o, 1'b0);
        check({tag, "_prep_allowed"}, prep_allowed_o, 1'b0);
        check({tag, "_operand_a"}, operand_a_o, 16'h0);
        check({tag, "_operand_b"}, operand_b_o, 16'h0);
        check({tag, "_window"}, input_px_gray_o, 72'h0);
    endtask

    // Every accepted byte must be the next one the model predicted; engines run only when allowed.
    always @(negedge clk_i) begin
        if (nreset_i) begin
            check("no_unexpected_run", (gcd_enable_o | prep_allowed_o) & ~allow_run, 1'b0);
            if (tx_valid_o && tx_ready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected: got byte %0h expected none", tx_byte_o);
                end else begin
                    check("tx_byte", tx_byte_o, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        check_all_zero("reset");
        nreset_i = 1'b1;
        tick();

        check("gcd_model_48_18", gcd_ref(48, 18), 6);
        check("gcd_model_28_21", gcd_ref(28, 21), 7);

        // bad opcode then two STATUS commands
        send_byte(8'h7E, 1'b1);
        model_op(8'h7E);
        check("badop_busy", busy_o, 1'b0);
        check("badop_tx_valid", tx_valid_o, 1'b0);
        send_byte(8'h03, 1'b1);
        model_op(8'h03);
        check("status1_valid", tx_valid_o, 1'b1);
        check("status1_literal", tx_byte_o, 8'h01);
        tick();
        check("status1_busy_after", busy_o, 1'b0);
        send_byte(8'h03, 1'b1);
        model_op(8'h03);
        check("status2_literal", tx_byte_o, 8'h61);
        tick();

        // GCD 48,18
        gcd_frame(16'd48, 16'd18);
        repeat (3) tick();
        check("gcd_enable_held", gcd_enable_o, 1'b1);
        check("gcd_busy", busy_o, 1'b1);
        gcd_done_pulse(16'd48, 16'd18);
        check("gcd_first_byte_literal", tx_byte_o, 8'h00);
        tick();
        check("gcd_second_byte_literal", tx_byte_o, 8'h06);
        check("gcd_busy_mid_tx", busy_o, 1'b1);
        tick();
        check("gcd_busy_after_tx", busy_o, 1'b0);
        check("gcd_tx_valid_after_tx", tx_valid_o, 1'b0);

        // Sobel window 0x10..0x18
        allow_run = 1'b1;
        send_byte(8'h02, 1'b1);
        model_op(8'h02);
        m_win = '0;
        for (int i = 0; i < 9; i++) begin
            m_win[8*i +: 8] = 8'(8'h10 + i);
            send_byte(8'(8'h10 + i), 1'b0);
        end
        check("sobel_prep_allowed", prep_allowed_o, 1'b1);
        check("sobel_window_model", input_px_gray_o, m_win);
        check("sobel_window_literal", input_px_gray_o, 72'h18_17_16_15_14_13_12_11_10);
        check("sobel_no_gcd_enable", gcd_enable_o, 1'b0);
        repeat (2) tick();
        output_px_sobel_i = 8'h5A;
        pixel_completed_i = 1'b1;
        exp_q.push_back(8'h5A);
        tick();
        pixel_completed_i = 1'b0;
        output_px_sobel_i = 8'h00;
        allow_run = 1'b0;
        check("sobel_tx_valid", tx_valid_o, 1'b1);
        check("sobel_tx_literal", tx_byte_o, 8'h5A);
        check("sobel_prep_dropped", prep_allowed_o, 1'b0);
        tick();
        check("sobel_busy_after_tx", busy_o, 1'b0);

        // frame_start abort after two GCD argument bytes, same-cycle STATUS opcode
        send_byte(8'h01, 1'b1);
        model_op(8'h01);
        send_byte(8'h00, 1'b0);
        send_byte(8'h30, 1'b0);
        send_byte(8'h03, 1'b1);
        model_op(8'h03);
        check("abort_status_valid", tx_valid_o, 1'b1);
        check("abort_status_literal", tx_byte_o, 8'h21);
        tick();
        repeat (5) tick();
        check("abort_busy", busy_o, 1'b0);
        check("abort_no_enable", gcd_enable_o, 1'b0);

        // stray byte during GCD_RUN, then 10-cycle tx stall
        gcd_frame(16'd28, 16'd21);
        send_byte(8'h55, 1'b0);
        err_bump();
        check("stray_byte_enable_held", gcd_enable_o, 1'b1);
        tx_ready_i = 1'b0;
        gcd_done_pulse(16'd28, 16'd21);
        for (int i = 0; i < 10; i++) begin
            check("stall_tx_valid", tx_valid_o, 1'b1);
            check("stall_tx_byte", tx_byte_o, 8'h00);
            tick();
        end
        tx_ready_i = 1'b1;
        tick();
        check("stall_second_byte", tx_byte_o, 8'h07);
        tick();
        check("stall_busy_after", busy_o, 1'b0);
        send_byte(8'h03, 1'b1);
        model_op(8'h03);
        check("status_after_stray_literal", tx_byte_o, 8'h22);
        tick();

        // done pulses while idle are ignored
        gcd_i             = 16'h1234;
        gcd_done_i        = 1'b1;
        pixel_completed_i = 1'b1;
        tick();
        gcd_done_i        = 1'b0;
        pixel_completed_i = 1'b0;
        gcd_i             = 16'h0;
        tick();
        check("stray_done_tx_valid", tx_valid_o, 1'b0);
        check("stray_done_busy", busy_o, 1'b0);

`ifdef SOBEL_GCD_CMD_TIMEOUT_EN
        gcd_frame(16'd100, 16'd75);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        err_bump();
        n_en = 0;
        while (gcd_enable_o && n_en < 40) begin
            n_en++;
            tick();
        end
        allow_run = 1'b0;
        check("timeout_enable_cycles", n_en, 16);
        check("timeout_tx_valid", tx_valid_o, 1'b1);
        check("timeout_tx_byte", tx_byte_o, 8'hFF);
        repeat (2) tick();
        check("timeout_busy_after", busy_o, 1'b0);
        send_byte(8'h03, 1'b1);
        model_op(8'h03);
        check("timeout_status_literal", tx_byte_o, 8'h23);
        tick();
`endif

        // asynchronous reset in the middle of GCD_RUN
        gcd_frame(16'd12, 16'd8);
        tick();
        nreset_i = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        m_err     = 0;
        m_last    = 0;
        exp_q.delete();
        allow_run = 1'b0;
        tick();
        nreset_i = 1'b1;
        tick();
        send_byte(8'h03, 1'b1);
        model_op(8'h03);
        check("post_reset_status_valid", tx_valid_o, 1'b1);
        check("post_reset_status_literal", tx_byte_o, 8'h00);
        repeat (3) tick();

        check("tx_queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sobel_gcd_cmd_ctrl.md
Name: sobel_gcd_cmd_ctrl

Overview:
- Command sequencer between the SPI byte transport (sobel_gcd_spi core) and the two engines (gcd_top, sobel_control).
- Decodes SPI byte frames into opcodes, assembles operands and 3x3 pixel windows, runs the selected engine, and returns result bytes.
- Sits directly downstream of the SPI byte layer and upstream of gcd_top and sobel_control.

Parameters:
- GCD_WIDTH, 16, operand/result width of gcd_top; must be a multiple of 8.
- PX_WIDTH, 8, gray/sobel pixel width; fixed at 8 by the byte protocol.
- TIMEOUT_CYCLES, 4096, engine-wait limit; used only with the optional feature.

Ports:
- clk_i  in  1  system clock.
- nreset_i  in  1  asynchronous active-low reset.
- frame_start_i  in  1  one-cycle pulse when CS asserts, already synchronised.
- rx_byte_i  in  8  received SPI byte.
- rx_valid_i  in  1  one-cycle pulse; rx_byte_i is valid.
- tx_byte_o  out  8  byte offered to the SPI shifter.
- tx_valid_o  out  1  tx_byte_o valid; held until accepted.
- tx_ready_i  in  1  shifter accepts tx_byte_o this cycle.
- operand_a_o  out  GCD_WIDTH  GCD operand A.
- operand_b_o  out  GCD_WIDTH  GCD operand B.
- gcd_enable_o  out  1  held high while GCD runs.
- gcd_i  in  GCD_WIDTH  GCD result.
- gcd_done_i  in  1  GCD result valid pulse.
- input_px_gray_o  out  9*PX_WIDTH  3x3 window, p0 in LSBs, raster order.
- prep_allowed_o  out  1  held high while Sobel runs.
- output_px_sobel_i  in  PX_WIDTH  Sobel magnitude.
- pixel_completed_i  in  1  Sobel result valid pulse.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, err_cnt 0, last_op 0.
- Opcodes (first byte of a frame):
  - 0x01 GCD: followed by A then B, MSB first, GCD_WIDTH/8 bytes each.
  - 0x02 SOBEL: followed by 9 pixel bytes p0..p8.
  - 0x03 STATUS: no argument bytes.
- States: IDLE, RX_ARGS, GCD_RUN, SOBEL_RUN, TX.
- IDLE:
  - On rx_valid_i, decode the opcode and load arg_cnt.
  - Any other opcode: err_cnt++ (saturates at 31), stay in IDLE.
- RX_ARGS:
  - Shift each byte into the operand/window register and decrement arg_cnt.
  - On the last byte, go to GCD_RUN or SOBEL_RUN on the next cycle.
- GCD_RUN:
  - gcd_enable_o=1, with operands stable.
  - On gcd_done_i: capture gcd_i, drop enable the next cycle, go to TX with GCD_WIDTH/8 bytes, MSB first.
- SOBEL_RUN:
  - prep_allowed_o=1.
  - On pixel_completed_i: capture output_px_sobel_i, go to TX with 1 byte.
- STATUS: go straight to TX with 1 byte = {busy_at_cmd(0), last_op[1:0], err_cnt[4:0]}.
- TX:
  - tx_valid_o=1 with the current byte.
  - Each cycle with tx_ready_i, advance to the next byte.
  - After the final accept, tx_valid_o=0 and return to IDLE.
- rx_valid_i outside IDLE/RX_ARGS: byte ignored, err_cnt++.
- frame_start_i: highest priority from any state.
  - Abort to IDLE, clear enables, tx_valid_o and arg_cnt.
  - A same-cycle rx_valid_i byte is decoded as the new opcode.
- Engine done pulse arriving while not in the matching RUN state: ignored.
- last_op is updated to 1/2/3 on each valid opcode.
- Latency: last argument byte to enable high = 1 cycle; done pulse to tx_valid_o = 1 cycle.
- Asynchronous reset mid-operation: immediate return to the reset values above.

Optional Feature:
- Macro: SOBEL_GCD_CMD_TIMEOUT_EN.
- Enabled:
  - A wait counter runs in GCD_RUN and SOBEL_RUN.
  - If TIMEOUT_CYCLES elapse without the done pulse: drop the enable, err_cnt++, go to TX.
  - TX sends 0xFF, repeated for each result byte.
- Disabled: no counter; the RUN states wait indefinitely, apart from frame_start_i or reset.

Decomposition:
- Package sobel_gcd_pkg holds:
  - opcode constants OP_GCD/OP_SOBEL/OP_STATUS;
  - state enum cmd_state_e;
  - ERR_CNT_W=5 and TIMEOUT_BYTE=8'hFF.
- One natural sub-module: sobel_gcd_tx_serializer, which loads up to GCD_WIDTH/8 bytes and handles tx_valid/tx_ready sequencing.

Test Plan:
- GCD: bytes 01,00,30,00,12 (48,18) -> gcd_enable_o high 1 cycle after the last byte; model returns 6 -> tx 0x00 then 0x06; busy_o falls after the second accept.
- Sobel: 02 then 9 bytes 0x10..0x18 -> input_px_gray_o p0=0x10 ... p8=0x18, prep_allowed_o high; model returns 0x5A -> tx 0x5A.
- Bad opcode 0x7E, then 03 -> status 0x01 (err_cnt=1, last_op=0); a following 03 -> 0x61.
- frame_start_i after 2 GCD argument bytes, with a same-cycle byte 0x03 -> no enable pulse; status byte returned.
- tx_ready_i held low for 10 cycles during TX -> tx_byte_o and tx_valid_o stay stable; nreset_i asserted mid GCD_RUN -> all outputs 0 immediately.
- With SOBEL_GCD_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16, GCD with no done pulse -> enable drops after 16 cycles; tx 0xFF,0xFF; err_cnt=1.
